// File: rtl/support_io_pkg.sv
// Shared constants for the support I/O mailbox slot.
//   - Register sub-addresses within the slot's 16-address window.
//   - Bit positions of the status byte (address MBX_STAT, read).
//   - Bit positions of the control byte (address MBX_STAT, write).
//   - Bit positions of the interrupt-enable byte (address MBX_IE).
package support_io_pkg;

    // Register map
    localparam logic [3:0] MBX_DATA = 4'd0;
    localparam logic [3:0] MBX_STAT = 4'd1;
    localparam logic [3:0] MBX_IE   = 4'd2;

    // Value driven for unmapped reads and for an empty data register
    localparam logic [7:0] RD_IDLE = 8'hFF;

    // Status byte bit positions
    localparam int unsigned STAT_UP_NE    = 0;
    localparam int unsigned STAT_DN_NF    = 1;
    localparam int unsigned STAT_OVF_UP   = 2;
    localparam int unsigned STAT_OVF_DN   = 3;
    localparam int unsigned STAT_UP_FULL  = 4;
    localparam int unsigned STAT_DN_EMPTY = 5;
    localparam int unsigned STAT_IRQ      = 6;

    // Control byte bit positions
    localparam int unsigned CTRL_CLR_OVF = 0;
    localparam int unsigned CTRL_FLUSH   = 1;

    // Interrupt-enable bit positions
    localparam int unsigned IE_UP_NE    = 0;
    localparam int unsigned IE_DN_EMPTY = 1;

endpackage

// File: rtl/support_mailbox_fifo.sv
// Synchronous byte FIFO used for both mailbox directions.
// Full/empty are judged on the level at the start of the cycle, so a push into a full FIFO is
// dropped even when a pop happens in the same cycle. Flush wins over push and pop.
// Ports:
//   clk_i, rst_i   clock, synchronous active-high reset
//   push, din      write request and data (ignored when full)
//   pop            advance the head (ignored when empty)
//   flush          empty the FIFO
//   dout           current head (valid when !empty)
//   full, empty    occupancy flags
//   level          number of stored bytes, 0..DEPTH
module support_mailbox_fifo
    import support_io_pkg::*;
#(
    parameter int unsigned DEPTH = 16,
    parameter int unsigned LW    = $clog2(DEPTH) + 1
) (
    input  logic          clk_i,
    input  logic          rst_i,
    input  logic          push,
    input  logic          pop,
    input  logic          flush,
    input  logic [7:0]    din,
    output logic [7:0]    dout,
    output logic          full,
    output logic          empty,
    output logic [LW-1:0] level
);

    localparam int unsigned AW = $clog2(DEPTH);

    logic [7:0]    mem_q [DEPTH];
    logic [AW-1:0] rd_ptr_q, wr_ptr_q;
    logic [LW-1:0] level_q, level_d;
    logic          push_ok, pop_ok;

    assign full    = (level_q == LW'(DEPTH));
    assign empty   = (level_q == '0);
    assign level   = level_q;
    assign push_ok = push & ~full & ~flush;
    assign pop_ok  = pop & ~empty & ~flush;
    assign dout    = mem_q[rd_ptr_q];

    always_comb begin
        level_d = level_q;
        unique case ({push_ok, pop_ok})
            2'b10:   level_d = level_q + 1'b1;
            2'b01:   level_d = level_q - 1'b1;
            default: level_d = level_q;
        endcase
    end

    // Pointers wrap naturally because DEPTH is a power of two
    always_ff @(posedge clk_i) begin
        if (rst_i || flush) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            if (push_ok) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (pop_ok)  rd_ptr_q <= rd_ptr_q + 1'b1;
            level_q <= level_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (push_ok) mem_q[wr_ptr_q] <= din;
    end

endmodule

// File: rtl/support_mailbox.sv
// Byte-wide mailbox on one slot of the support I/O switch.
// Down path: CPU writes to MBX_DATA -> down FIFO -> tx_* stream to the support processor.
// Up path:   rx_* stream -> up FIFO -> CPU reads of MBX_DATA (popped when the read strobe ends).
// Optional feature macro: SUPPORT_MAILBOX_IRQ_EN adds irq_o and the IE register at MBX_IE.
// Ports:
//   clk_i, rst_i         clock, synchronous active-high reset
//   A_i, D_i, D_o        sub-address, write data, combinational read data
//   nrd_i, nwr_i         active-low strobes for this slot
//   tx_data_o/valid_o/ready_i   down stream (head of down FIFO, 8'h00 when empty)
//   rx_data_i/valid_i/ready_o   up stream
//   irq_o                registered interrupt (only with SUPPORT_MAILBOX_IRQ_EN)
module support_mailbox
    import support_io_pkg::*;
#(
    parameter int unsigned DEPTH = 16,
    parameter int unsigned LW    = $clog2(DEPTH) + 1
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic [3:0] A_i,
    input  logic [7:0] D_i,
    output logic [7:0] D_o,
    input  logic       nrd_i,
    input  logic       nwr_i,
    output logic [7:0] tx_data_o,
    output logic       tx_valid_o,
    input  logic       tx_ready_i,
    input  logic [7:0] rx_data_i,
    input  logic       rx_valid_i,
    output logic       rx_ready_o
`ifdef SUPPORT_MAILBOX_IRQ_EN
    ,
    output logic       irq_o
`endif
);

    // Strobe edge detection. The arm flags stop a strobe that is already low when reset
    // releases from producing any event until it has been seen high again.
    logic       nwr_q, nrd_q, wr_arm_q, rd_arm_q;
    logic [3:0] rd_addr_q;
    logic       wr_ev, rd_start, rd_end;

    assign wr_ev    = ~nwr_i & nwr_q & wr_arm_q;
    assign rd_start = ~nrd_i & nrd_q & rd_arm_q;
    assign rd_end   = nrd_i & ~nrd_q & rd_arm_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            nwr_q     <= 1'b1;
            nrd_q     <= 1'b1;
            wr_arm_q  <= nwr_i;
            rd_arm_q  <= nrd_i;
            rd_addr_q <= '0;
        end else begin
            nwr_q    <= nwr_i;
            nrd_q    <= nrd_i;
            wr_arm_q <= wr_arm_q | nwr_i;
            rd_arm_q <= rd_arm_q | nrd_i;
            if (rd_start) rd_addr_q <= A_i;
        end
    end

    // Register decode
    logic wr_data, wr_ctrl, flush, clr_ovf;

    assign wr_data = wr_ev & (A_i == MBX_DATA);
    assign wr_ctrl = wr_ev & (A_i == MBX_STAT);
    assign flush   = wr_ctrl & D_i[CTRL_FLUSH];
    assign clr_ovf = wr_ctrl & D_i[CTRL_CLR_OVF];

    // FIFOs
    logic [7:0]    dn_dout, up_dout;
    logic          dn_full, dn_empty, up_full, up_empty;
    logic [LW-1:0] dn_level, up_level;
    logic          dn_pop, up_push, up_pop;

    assign dn_pop  = tx_valid_o & tx_ready_i;
    assign up_push = rx_valid_i & rx_ready_o;
    assign up_pop  = rd_end & (rd_addr_q == MBX_DATA);

    support_mailbox_fifo #(
        .DEPTH (DEPTH),
        .LW    (LW)
    ) u_dn_fifo (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .push  (wr_data),
        .pop   (dn_pop),
        .flush (flush),
        .din   (D_i),
        .dout  (dn_dout),
        .full  (dn_full),
        .empty (dn_empty),
        .level (dn_level)
    );

    support_mailbox_fifo #(
        .DEPTH (DEPTH),
        .LW    (LW)
    ) u_up_fifo (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .push  (up_push),
        .pop   (up_pop),
        .flush (flush),
        .din   (rx_data_i),
        .dout  (up_dout),
        .full  (up_full),
        .empty (up_empty),
        .level (up_level)
    );

    assign tx_valid_o = ~dn_empty;
    assign tx_data_o  = dn_empty ? 8'h00 : dn_dout;
    assign rx_ready_o = ~up_full;

    // Sticky overflow flags; a new overflow in the same cycle as a clear wins
    logic ovf_up_q, ovf_up_d, ovf_dn_q, ovf_dn_d;

    always_comb begin
        ovf_up_d = ovf_up_q;
        ovf_dn_d = ovf_dn_q;
        if (clr_ovf) begin
            ovf_up_d = 1'b0;
            ovf_dn_d = 1'b0;
        end
        if (rx_valid_i & up_full) ovf_up_d = 1'b1;
        if (wr_data & dn_full)    ovf_dn_d = 1'b1;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            ovf_up_q <= 1'b0;
            ovf_dn_q <= 1'b0;
        end else begin
            ovf_up_q <= ovf_up_d;
            ovf_dn_q <= ovf_dn_d;
        end
    end

    // Interrupt
    logic irq_state;

`ifdef SUPPORT_MAILBOX_IRQ_EN
    logic [1:0] ie_q;
    logic [1:0] irq_cond;
    logic       irq_q;

    always_comb begin
        irq_cond              = '0;
        irq_cond[IE_UP_NE]    = ~up_empty;
        irq_cond[IE_DN_EMPTY] = dn_empty;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            ie_q  <= '0;
            irq_q <= 1'b0;
        end else begin
            if (wr_ev && (A_i == MBX_IE)) ie_q <= D_i[1:0];
            irq_q <= |(ie_q & irq_cond);
        end
    end

    assign irq_o     = irq_q;
    assign irq_state = irq_q;
`else
    assign irq_state = 1'b0;
`endif

    // Read mux: combinational on A_i so the switch sees stable data for the whole strobe
    logic [7:0] status;

    always_comb begin
        status                = '0;
        status[STAT_UP_NE]    = ~up_empty;
        status[STAT_DN_NF]    = ~dn_full;
        status[STAT_OVF_UP]   = ovf_up_q;
        status[STAT_OVF_DN]   = ovf_dn_q;
        status[STAT_UP_FULL]  = up_full;
        status[STAT_DN_EMPTY] = dn_empty;
        status[STAT_IRQ]      = irq_state;
    end

    always_comb begin
        D_o = RD_IDLE;
        case (A_i)
            MBX_DATA: D_o = up_empty ? RD_IDLE : up_dout;
            MBX_STAT: D_o = status;
`ifdef SUPPORT_MAILBOX_IRQ_EN
            MBX_IE:   D_o = {6'b0, ie_q};
`endif
            default:  D_o = RD_IDLE;
        endcase
    end

    level_in_range: assert property (@(posedge clk_i) disable iff (rst_i)
        (dn_level <= LW'(DEPTH)) && (up_level <= LW'(DEPTH)));

endmodule
